coord_readout_ctrl: RTL and testbench

Time-shares a single 16-glyph seven-segment decoder across four HEX digits and arbitrates three coordinate requesters (X, Y, Z) for ownership of that readout. The winning axis's 3-digit value is latched, decoded digit-by-digit over four cycles, then held for a dwell period before the next arbitration. Sits between the 3D-object coordinate logic and the board HEX3..HEX0 pins.

---
 rtl/hex_display_pkg.sv | 38 +++
 rtl/hex_glyph_rom.sv | 31 +++
 rtl/coord_readout_ctrl.sv | 136 +++++++++++++
 tb/tb_coord_readout_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the coordinate HEX readout: FSM states,
// axis ids, axis glyph codes and the round-robin requester pick.
package hex_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DECODE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam logic [1:0] AX_X = 2'd0;
    localparam logic [1:0] AX_Y = 2'd1;
    localparam logic [1:0] AX_Z = 2'd2;

    localparam logic [3:0] GL_X = 4'd10;
    localparam logic [3:0] GL_Y = 4'd11;
    localparam logic [3:0] GL_Z = 4'd12;

    localparam logic [6:0] HEX_BLANK = 7'h7F;

    // Search order starts at the axis after the previous owner; returns
    // 'last' itself only when it is the sole requester.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] pick;
        case (last)
            AX_X:    pick = req[1] ? AX_Y : (req[2] ? AX_Z : AX_X);
            AX_Y:    pick = req[2] ? AX_Z : (req[0] ? AX_X : AX_Y);
            default: pick = req[0] ? AX_X : (req[1] ? AX_Y : AX_Z);
        endcase
        return pick;
    endfunction

    function automatic logic [2:0] axis_onehot(input logic [1:0] axis);
        return 3'b001 << axis;
    endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// 16-entry glyph table: 4-bit code to active-low seven-segment pattern
// (bit0 = a .. bit6 = g, 1 = unlit). Codes 10..15 are X, Y, Z, R, S, T.
module hex_glyph_rom (
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (code)
            4'd0:  seg = 7'h40;
            4'd1:  seg = 7'h79;
            4'd2:  seg = 7'h24;
            4'd3:  seg = 7'h30;
            4'd4:  seg = 7'h19;
            4'd5:  seg = 7'h12;
            4'd6:  seg = 7'h02;
            4'd7:  seg = 7'h78;
            4'd8:  seg = 7'h00;
            4'd9:  seg = 7'h18;
            4'd10: seg = 7'h09;
            4'd11: seg = 7'h11;
            4'd12: seg = 7'h24;
            4'd13: seg = 7'h2F;
            4'd14: seg = 7'h12;
            4'd15: seg = 7'h4E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/coord_readout_ctrl.sv
// Arbitrates X/Y/Z requesters for one shared glyph decoder driving HEX3..HEX0.
// Optional BLANK_LEADING_ZERO_EN blanks leading zeros on hex2/hex1.
module coord_readout_ctrl
    import hex_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [11:0] val_x,
    input  logic [11:0] val_y,
    input  logic [11:0] val_z,
    output logic [2:0]  ack,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        busy,
    output logic [1:0]  cur_axis
);

    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] LOAD   = ST_LOAD;
    localparam logic [1:0] DECODE = ST_DECODE;
    localparam logic [1:0] HOLD   = ST_HOLD;

    logic [1:0]       state;
    logic [1:0]       idx;
    logic [1:0]       last_grant;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ack_q;
    logic [11:0]      val_p0;
    logic [1:0]       axis_p0;
    logic [3:0][6:0]  hex_q;

    logic [1:0]  win;
    logic [11:0] win_val;
    logic [3:0]  code;
    logic [6:0]  rom_seg;
    logic        blank;
    logic [6:0]  dec_seg;

    assign win = rr_pick(last_grant, req);

    always_comb begin
        case (win)
            AX_X:    win_val = val_x;
            AX_Y:    win_val = val_y;
            default: win_val = val_z;
        endcase
    end

    // Digit 3 carries the axis letter; the lower three carry the latched nibbles.
    always_comb begin
        case (idx)
            2'd3:    code = GL_X + {2'b00, axis_p0};
            2'd2:    code = val_p0[11:8];
            2'd1:    code = val_p0[7:4];
            default: code = val_p0[3:0];
        endcase
    end

    hex_glyph_rom u_rom (
        .code (code),
        .seg  (rom_seg)
    );

`ifdef BLANK_LEADING_ZERO_EN
    assign blank = ((idx == 2'd2) && (val_p0[11:8] == 4'd0)) ||
                   ((idx == 2'd1) && (val_p0[11:4] == 8'd0));
`else
    assign blank = 1'b0;
`endif

    assign dec_seg = blank ? HEX_BLANK : rom_seg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 2'd0;
            last_grant <= AX_Z;
            cnt        <= '0;
            ack_q      <= 3'b000;
            val_p0     <= 12'h000;
            axis_p0    <= AX_X;
            hex_q      <= {4{HEX_BLANK}};
        end else begin
            ack_q <= 3'b000;
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        val_p0  <= win_val;
                        axis_p0 <= win;
                        ack_q   <= axis_onehot(win);
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    last_grant <= axis_p0;
                    idx        <= 2'd3;
                    cnt        <= '0;
                    state      <= DECODE;
                end
                DECODE: begin
                    hex_q[idx] <= dec_seg;
                    if (idx == 2'd0) begin
                        state <= HOLD;
                    end else begin
                        idx <= idx - 2'd1;
                    end
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign busy     = (state != IDLE);
    assign cur_axis = axis_p0;
    assign hex3     = hex_q[3];
    assign hex2     = hex_q[2];
    assign hex1     = hex_q[1];
    assign hex0     = hex_q[0];

endmodule

// File: tb/tb_coord_readout_ctrl.sv
// Bench for coord_readout_ctrl with a short dwell: directed pages, reset
// cases and random pages checked against a page-level reference model.
module tb_coord_readout_ctrl;

    localparam int DW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req   = 3'b000;
    logic [11:0] val_x = 12'h000;
    logic [11:0] val_y = 12'h000;
    logic [11:0] val_z = 12'h000;
    logic [2:0]  ack;
    logic [6:0]  hex3, hex2, hex1, hex0;
    logic        busy;
    logic [1:0]  cur_axis;

    int total = 0;
    int bad   = 0;
    int last_g = 2;
    logic [6:0] exp_hex [4];

    coord_readout_ctrl #(.DWELL_CYCLES(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .val_x    (val_x),
        .val_y    (val_y),
        .val_z    (val_z),
        .ack      (ack),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .busy     (busy),
        .cur_axis (cur_axis)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Segment pattern built from the per-segment lists of codes that leave it unlit.
    function automatic logic [6:0] glyph(input int code);
        logic [15:0] unlit [7];
        logic [6:0]  s;
        unlit[0] = 16'((1<<1)|(1<<4)|(1<<10)|(1<<11)|(1<<13));
        unlit[1] = 16'((1<<5)|(1<<6)|(1<<13)|(1<<14)|(1<<15));
        unlit[2] = 16'((1<<2)|(1<<12)|(1<<13)|(1<<15));
        unlit[3] = 16'((1<<1)|(1<<4)|(1<<7)|(1<<9)|(1<<10)|(1<<13)|(1<<15));
        unlit[4] = 16'((1<<1)|(1<<3)|(1<<4)|(1<<5)|(1<<7)|(1<<9)|(1<<11)|(1<<14));
        unlit[5] = 16'((1<<1)|(1<<2)|(1<<3)|(1<<7)|(1<<12)|(1<<13));
        unlit[6] = 16'((1<<0)|(1<<1)|(1<<7)|(1<<15));
        for (int k = 0; k < 7; k++) s[k] = unlit[k][code];
        return s;
    endfunction

    function automatic logic [6:0] exp_digit(input int d, input int axis, input logic [11:0] v);
        int nib;
        if (d == 3) return glyph(10 + axis);
        nib = int'((v >> (4 * d)) & 12'hF);
`ifdef BLANK_LEADING_ZERO_EN
        if (d == 2 && v[11:8] == 4'd0) return 7'h7F;
        if (d == 1 && v[11:4] == 8'd0) return 7'h7F;
`endif
        return glyph(nib);
    endfunction

    function automatic int pick(input logic [2:0] r);
        int c;
        for (int k = 1; k <= 3; k++) begin
            c = (last_g + k) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_page(input logic [2:0] r, input logic [11:0] vx, input logic [11:0] vy,
                           input logic [11:0] vz, input bit keep, input logic [2:0] pulse);
        int win;
        logic [11:0] v;
        logic [2:0] oh;
        val_x = vx; val_y = vy; val_z = vz;
        req = r;
        win = pick(r);
        v = (win == 0) ? vx : ((win == 1) ? vy : vz);
        oh = 3'b001 << win;
        step();
        chk("ack_pulse", 16'(ack), 16'(oh));
        chk("busy_load", 16'(busy), 16'd1);
        chk("cur_axis", 16'(cur_axis), 16'(win));
        last_g = win;
        if (!keep) req = r & ~oh;
        val_x = 12'($urandom); val_y = 12'($urandom); val_z = 12'($urandom);
        for (int d = 0; d < 4; d++) exp_hex[d] = exp_digit(d, win, v);
        repeat (5) step();
        chk("hex3", 16'(hex3), 16'(exp_hex[3]));
        chk("hex2", 16'(hex2), 16'(exp_hex[2]));
        chk("hex1", 16'(hex1), 16'(exp_hex[1]));
        chk("hex0", 16'(hex0), 16'(exp_hex[0]));
        chk("ack_low_hold", 16'(ack), 16'd0);
        if (pulse != 3'b000) begin
            req = pulse;
            step();
            req = 3'b000;
            repeat (2) step();
        end else begin
            repeat (3) step();
        end
        chk("busy_hold_end", 16'(busy), 16'd1);
        step();
        chk("busy_idle", 16'(busy), 16'd0);
        chk("ack_idle", 16'(ack), 16'd0);
    endtask

    initial begin
        int w;
        repeat (2) step();
        chk("rst_hex3", 16'(hex3), 16'h7F);
        chk("rst_hex2", 16'(hex2), 16'h7F);
        chk("rst_hex1", 16'(hex1), 16'h7F);
        chk("rst_hex0", 16'(hex0), 16'h7F);
        chk("rst_ack", 16'(ack), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_axis", 16'(cur_axis), 16'd0);
        reset = 1'b0;
        step();

        do_page(3'b001, 12'h123, 12'h456, 12'h789, 1'b0, 3'b000);
        chk("x123_hex3", 16'(hex3), 16'h09);
        chk("x123_hex2", 16'(hex2), 16'h79);
        chk("x123_hex1", 16'(hex1), 16'h24);
        chk("x123_hex0", 16'(hex0), 16'h30);

        // Reset in the middle of HOLD
        req = 3'b010; val_y = 12'h777;
        step();
        chk("pre_rst_ack", 16'(ack), 16'b010);
        req = 3'b000;
        repeat (6) step();
        reset = 1'b1;
        #1;
        chk("midhold_hex3", 16'(hex3), 16'h7F);
        chk("midhold_hex0", 16'(hex0), 16'h7F);
        chk("midhold_ack", 16'(ack), 16'd0);
        chk("midhold_busy", 16'(busy), 16'd0);
        last_g = 2;
        step();
        reset = 1'b0;
        step();

        for (int p = 0; p < 4; p++)
            do_page(3'b111, 12'h321, 12'h654, 12'h987, 1'b1, 3'b000);
        req = 3'b000;

        do_page(3'b001, 12'h208, 12'h000, 12'h000, 1'b0, 3'b010);
        repeat (3) step();
        chk("pulse_busy", 16'(busy), 16'd0);
        chk("pulse_ack", 16'(ack), 16'd0);
        chk("pulse_axis", 16'(cur_axis), 16'd0);
        chk("pulse_hex3", 16'(hex3), 16'(exp_hex[3]));
        chk("pulse_hex1", 16'(hex1), 16'(exp_hex[1]));

        do_page(3'b100, 12'h000, 12'h000, 12'h005, 1'b0, 3'b000);
`ifdef BLANK_LEADING_ZERO_EN
        chk("z005_hex2", 16'(hex2), 16'h7F);
        chk("z005_hex1", 16'(hex1), 16'h7F);
`else
        chk("z005_hex2", 16'(hex2), 16'h40);
        chk("z005_hex1", 16'(hex1), 16'h40);
`endif
        chk("z005_hex0", 16'(hex0), 16'h12);
        chk("z005_hex3", 16'(hex3), 16'h24);

        do_page(3'b010, 12'h000, 12'hDEF, 12'h000, 1'b0, 3'b000);
        chk("rst_glyph_r", 16'(hex2), 16'h2F);
        chk("rst_glyph_s", 16'(hex1), 16'h12);
        chk("rst_glyph_t", 16'(hex0), 16'h4E);
        chk("def_axis", 16'(cur_axis), 16'd1);

        for (int p = 0; p < 12; p++)
            do_page(3'($urandom_range(1, 7)), 12'($urandom), 12'($urandom), 12'($urandom),
                    1'($urandom), 3'b000);
        req = 3'b000;
        step();

        // Reset while the ack pulse is on the wire
        req = 3'b010;
        w = pick(3'b010);
        step();
        chk("load_ack", 16'(ack), 16'(3'b001 << w));
        reset = 1'b1;
        #1;
        chk("load_rst_ack", 16'(ack), 16'd0);
        chk("load_rst_busy", 16'(busy), 16'd0);
        chk("load_rst_hex2", 16'(hex2), 16'h7F);
        req = 3'b000;
        step();
        reset = 1'b0;
        last_g = 2;
        repeat (3) step();
        chk("final_busy", 16'(busy), 16'd0);
        chk("final_axis", 16'(cur_axis), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
